escalonador_semaforo: RTL and testbench

Phase scheduler for a two-road intersection with a pedestrian crossing. Sequences road lights A and B through green/yellow/all-red phases, latches pedestrian button requests and serves them at the next all-red boundary. Phase durations are run-time configurable through a write port. Sits above the light-output logic as the sole source of the A/B/pedestrian light codes.

---
 rtl/escalonador_semaforo_pkg.sv | 57 +++++
 rtl/escalonador_semaforo_contador_fase.sv | 31 +++
 rtl/escalonador_semaforo.sv | 109 ++++++++++
 tb/tb_escalonador_semaforo.sv | 192 +++++++++++++++++++
 4 files changed

// File: rtl/escalonador_semaforo_pkg.sv
// Shared definitions for the intersection phase scheduler: phase codes, light
// encodings, configuration selectors and phase-to-duration mapping.
package escalonador_semaforo_pkg;

  typedef enum logic [2:0] {
    A_VERDE   = 3'd0,
    A_AMARELO = 3'd1,
    VERM_AB   = 3'd2,
    B_VERDE   = 3'd3,
    B_AMARELO = 3'd4,
    VERM_BA   = 3'd5,
    PEDESTRE  = 3'd6
  } fase_e;

  localparam logic [2:0] LUZ_VERDE    = 3'b001;
  localparam logic [2:0] LUZ_AMARELO  = 3'b010;
  localparam logic [2:0] LUZ_VERMELHO = 3'b100;

  localparam logic [1:0] SEL_VERDE    = 2'd0;
  localparam logic [1:0] SEL_AMARELO  = 2'd1;
  localparam logic [1:0] SEL_VERMELHO = 2'd2;
  localparam logic [1:0] SEL_PEDESTRE = 2'd3;

  // Both greens share one duration register, as do both yellows and both all-reds.
  function automatic logic [1:0] sel_de_fase(input fase_e f);
    logic [1:0] s;
    case (f)
      A_VERDE, B_VERDE:     s = SEL_VERDE;
      A_AMARELO, B_AMARELO: s = SEL_AMARELO;
      VERM_AB, VERM_BA:     s = SEL_VERMELHO;
      PEDESTRE:             s = SEL_PEDESTRE;
      default:              s = SEL_VERDE;
    endcase
    return s;
  endfunction

  function automatic logic [2:0] luz_a(input fase_e f);
    logic [2:0] l;
    case (f)
      A_VERDE:   l = LUZ_VERDE;
      A_AMARELO: l = LUZ_AMARELO;
      default:   l = LUZ_VERMELHO;
    endcase
    return l;
  endfunction

  function automatic logic [2:0] luz_b(input fase_e f);
    logic [2:0] l;
    case (f)
      B_VERDE:   l = LUZ_VERDE;
      B_AMARELO: l = LUZ_AMARELO;
      default:   l = LUZ_VERMELHO;
    endcase
    return l;
  endfunction

endpackage

// File: rtl/escalonador_semaforo_contador_fase.sv
// Loadable down-counter timing the current phase; zero_o marks the last cycle.
module contador_fase #(
  parameter int            W       = 8,
  parameter logic [W-1:0]  RST_VAL = '0
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load_i,
  input  logic [W-1:0] load_val_i,
  output logic [W-1:0] cnt_o,
  output logic         zero_o
);

  localparam logic [W-1:0] UM = {{(W-1){1'b0}}, 1'b1};

  logic [W-1:0] cnt_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= RST_VAL;
    end else if (load_i) begin
      cnt_q <= load_val_i;
    end else if (cnt_q != '0) begin
      cnt_q <= cnt_q - UM;
    end
  end

  assign cnt_o  = cnt_q;
  assign zero_o = (cnt_q == '0);

endmodule

// File: rtl/escalonador_semaforo.sv
// Two-road intersection phase scheduler with latched pedestrian requests and
// run-time configurable phase durations.
module escalonador_semaforo
  import escalonador_semaforo_pkg::*;
#(
  parameter int           W          = 8,
  parameter logic [W-1:0] T_VERDE    = 3,
  parameter logic [W-1:0] T_AMARELO  = 1,
  parameter logic [W-1:0] T_VERMELHO = 2,
  parameter logic [W-1:0] T_PEDESTRE = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         bt,
  input  logic         cfg_we,
  input  logic [1:0]   cfg_sel,
  input  logic [W-1:0] cfg_data,
  output logic [2:0]   A,
  output logic [2:0]   B,
  output logic         P,
  output logic [2:0]   fase,
  output logic         pendente
);

  localparam logic [W-1:0] UM = {{(W-1){1'b0}}, 1'b1};

  fase_e        estado_q, estado_d;
  logic         pendente_q, prox_q;
  logic [2:0]   a_q, b_q;
  logic         p_q;
  logic [W-1:0] dur_q [4];
  logic [W-1:0] cnt;
  logic         fim_fase;
  logic [W-1:0] carga_d;

  contador_fase #(
    .W       (W),
    .RST_VAL (T_VERDE - UM)
  ) u_contador (
    .clk        (clk),
    .rst_n      (rst),
    .load_i     (fim_fase),
    .load_val_i (carga_d),
    .cnt_o      (cnt),
    .zero_o     (fim_fase)
  );

  // PEDESTRE is inserted only at the all-red boundaries; prox_q remembers
  // which road resumes afterwards.
  always_comb begin
    estado_d = estado_q;
    if (fim_fase) begin
      case (estado_q)
        A_VERDE:   estado_d = A_AMARELO;
        A_AMARELO: estado_d = VERM_AB;
        VERM_AB:   estado_d = pendente_q ? PEDESTRE : B_VERDE;
        B_VERDE:   estado_d = B_AMARELO;
        B_AMARELO: estado_d = VERM_BA;
        VERM_BA:   estado_d = pendente_q ? PEDESTRE : A_VERDE;
        PEDESTRE:  estado_d = prox_q ? B_VERDE : A_VERDE;
        default:   estado_d = A_VERDE;
      endcase
    end
  end

  assign carga_d = dur_q[sel_de_fase(estado_d)] - UM;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      estado_q   <= A_VERDE;
      pendente_q <= 1'b0;
      prox_q     <= 1'b0;
      a_q        <= LUZ_VERDE;
      b_q        <= LUZ_VERMELHO;
      p_q        <= 1'b0;
    end else begin
      estado_q <= estado_d;
      a_q      <= luz_a(estado_d);
      b_q      <= luz_b(estado_d);
      p_q      <= (estado_d == PEDESTRE);
      // Entering PEDESTRE serves the request and wins over a coincident press.
      if (fim_fase && estado_d == PEDESTRE) begin
        pendente_q <= 1'b0;
        prox_q     <= (estado_q == VERM_AB);
      end else if (bt && estado_q != PEDESTRE) begin
        pendente_q <= 1'b1;
      end
    end
  end

  // Written values take effect only at the next load, never mid-countdown.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      dur_q[SEL_VERDE]    <= T_VERDE;
      dur_q[SEL_AMARELO]  <= T_AMARELO;
      dur_q[SEL_VERMELHO] <= T_VERMELHO;
      dur_q[SEL_PEDESTRE] <= T_PEDESTRE;
    end else if (cfg_we) begin
      dur_q[cfg_sel] <= (cfg_data == '0) ? UM : cfg_data;
    end
  end

  assign A        = a_q;
  assign B        = b_q;
  assign P        = p_q;
  assign fase     = estado_q;
  assign pendente = pendente_q;

endmodule

// File: tb/tb_escalonador_semaforo.sv
// Directed bench for escalonador_semaforo: phase sequence, pedestrian service,
// configuration writes, asynchronous reset and an irregular-duty clock.
`timescale 1ns/100ps
module tb_escalonador_semaforo;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       bt = 1'b0;
  logic       cfg_we = 1'b0;
  logic [1:0] cfg_sel = 2'd0;
  logic [7:0] cfg_data = 8'd0;
  logic [2:0] A, B, fase;
  logic       P, pendente;

  int checks = 0;
  int errors = 0;
  bit irr = 1'b0;
  logic [15:0] pat = 16'b0111100101000011;
  realtime last_pos = 0.0;

  escalonador_semaforo dut (
    .clk      (clk),
    .rst      (rst),
    .bt       (bt),
    .cfg_we   (cfg_we),
    .cfg_sel  (cfg_sel),
    .cfg_data (cfg_data),
    .A        (A),
    .B        (B),
    .P        (P),
    .fase     (fase),
    .pendente (pendente)
  );

  always begin
    if (!irr) begin
      #5 clk = ~clk;
    end else begin
      for (int i = 0; i < 16; i++) begin
        clk = pat[15-i];
        #1;
      end
    end
  end

  always @(posedge clk) last_pos = $realtime;

  // Outside reset, every output change must coincide with a rising edge.
  always @(fase or A or B or P or pendente) begin
    if (rst === 1'b1) begin
      checks++;
      assert ($realtime == last_pos) else begin
        errors++;
        $error("FAIL edge_sync: output change at %0t, last rising edge %0t", $realtime, last_pos);
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, observed timeout, required completion");
    $fatal(1, "timeout");
  end

  function automatic logic [2:0] exp_a(int f);
    return (f == 0) ? 3'b001 : (f == 1) ? 3'b010 : 3'b100;
  endfunction

  function automatic logic [2:0] exp_b(int f);
    return (f == 3) ? 3'b001 : (f == 4) ? 3'b010 : 3'b100;
  endfunction

  task automatic chk3(string tag, logic [2:0] obs, logic [2:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic chk1(string tag, logic obs, logic exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic check_state(string tag, int f, logic pe);
    chk3({tag, " fase"}, fase, f[2:0]);
    chk3({tag, " A"}, A, exp_a(f));
    chk3({tag, " B"}, B, exp_b(f));
    chk1({tag, " P"}, P, (f == 6));
    chk1({tag, " pendente"}, pendente, pe);
  endtask

  task automatic edge_();
    @(posedge clk);
    #0.2;
  endtask

  // Asserts reset between edges, checks its immediate effect, releases it
  // away from an edge; the caller then sits in cycle 0.
  task automatic do_reset(string tag);
    bt = 1'b0;
    cfg_we = 1'b0;
    rst = 1'b0;
    #0.3;
    check_state({tag, " reset"}, 0, 1'b0);
    edge_();
    rst = 1'b1;
  endtask

  int exp1[25]  = '{0,0,0,1,2,2,3,3,3,4,5,5,0,0,0,1,2,2,3,3,3,4,5,5,0};
  int exp2[23]  = '{0,0,0,1,2,2,6,6,6,6,3,3,3,4,5,5,0,0,0,1,2,2,3};
  bit pend2[23] = '{0,0,1,1,1,1,0,0,0,0,0,0,0,0,0,0,0,0,0,0,0,0,0};
  int exp4[30]  = '{0,0,0,1,2,2,3,3,3,3,3,4,4,4,5,5,0,0,0,0,0,1,2,2,3,3,3,3,3,4};

  initial begin
    #1;
    // Defaults, no requests: period 12
    do_reset("t1");
    for (int c = 0; c < 25; c++) begin
      check_state($sformatf("t1 c%0d", c), exp1[c], 1'b0);
      edge_();
    end

    // Single press at cycle 1 -> PEDESTRE after the A-side all-red
    do_reset("t2");
    for (int c = 0; c < 23; c++) begin
      check_state($sformatf("t2 c%0d", c), exp2[c], pend2[c]);
      bt = (c == 1);
      edge_();
    end
    bt = 1'b0;

    // Presses at 1, 2 and 7 (inside PEDESTRE) -> one service only
    do_reset("t3");
    for (int c = 0; c < 23; c++) begin
      check_state($sformatf("t3 c%0d", c), exp2[c], pend2[c]);
      bt = (c == 1 || c == 2 || c == 7);
      edge_();
    end
    bt = 1'b0;

    // Verde=5 at cycle 1, amarelo=3 on the same edge as its load, amarelo=0 later
    do_reset("t4");
    for (int c = 0; c < 30; c++) begin
      check_state($sformatf("t4 c%0d", c), exp4[c], 1'b0);
      cfg_we = 1'b0;
      if (c == 1)  begin cfg_we = 1'b1; cfg_sel = 2'd0; cfg_data = 8'd5; end
      if (c == 2)  begin cfg_we = 1'b1; cfg_sel = 2'd1; cfg_data = 8'd3; end
      if (c == 12) begin cfg_we = 1'b1; cfg_sel = 2'd1; cfg_data = 8'd0; end
      edge_();
    end
    cfg_we = 1'b0;

    // Reset in B_VERDE with a pending request, between edges
    do_reset("t5");
    for (int c = 0; c < 8; c++) begin
      check_state($sformatf("t5 c%0d", c), exp1[c], (c == 7));
      bt = (c == 6);
      if (c < 7) edge_();
    end
    bt = 1'b0;
    #2;
    rst = 1'b0;
    #0.2;
    check_state("t5 midreset", 0, 1'b0);
    edge_();
    rst = 1'b1;
    for (int c = 0; c < 13; c++) begin
      check_state($sformatf("t5r c%0d", c), exp1[c], 1'b0);
      edge_();
    end

    // Irregular-duty clock with bt toggling, including inside PEDESTRE
    irr = 1'b1;
    edge_();
    do_reset("t6");
    for (int c = 0; c < 23; c++) begin
      check_state($sformatf("t6 c%0d", c), exp2[c], pend2[c]);
      bt = (c < 10) && (c % 2 == 1);
      edge_();
    end
    bt = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
